// File: rtl/pipe_pkg.sv
// pipe_pkg -- shared definitions for the skid-buffered pipeline stage.
//   state_t   : occupancy encoding of the two-entry stage (EMPTY/ONE/FULL)
//   HALT_NONE : HALT_BIT value that disables halt-hold
//   PERF_W    : width of the optional stall/bubble counters
//   sat_inc   : saturating increment used by those counters
package pipe_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'b00,   // nothing held
      ONE   = 2'b01,   // main entry M valid
      FULL  = 2'b11    // M and skid entry S valid
   } state_t;

   localparam int HALT_NONE = -1;
   localparam int PERF_W    = 16;

   // Increment by one when en is set, sticking at all-ones.
   function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v,
                                                 input logic              en);
      logic [PERF_W-1:0] r;
      r = v;
      if (en && (v != {PERF_W{1'b1}})) begin
         r = v + PERF_W'(1);
      end
      return r;
   endfunction

endpackage

// File: rtl/pipe_entry.sv
// pipe_entry -- one storage slot of the pipeline stage (data + control).
// Ports:
//   clk, rst         : clock (rising edge) / asynchronous active-low reset
//   load             : capture d_data/d_ctrl at the next edge
//   clr_ctrl         : zero the control field at the next edge; data kept.
//                      Takes priority over load.
//   d_data, d_ctrl   : value to capture
//   q_data, q_ctrl   : held value
module pipe_entry
   import pipe_pkg::*;
#(
   parameter int DATA_W = 48,
   parameter int CTRL_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              clr_ctrl,
   input  logic [DATA_W-1:0] d_data,
   input  logic [CTRL_W-1:0] d_ctrl,
   output logic [DATA_W-1:0] q_data,
   output logic [CTRL_W-1:0] q_ctrl
);

   logic [DATA_W-1:0] data_q, data_d;
   logic [CTRL_W-1:0] ctrl_q, ctrl_d;

   always_comb begin
      data_d = data_q;
      ctrl_d = ctrl_q;
      if (clr_ctrl) begin
         // Killing a beat only needs its control gone; payload is don't-care.
         ctrl_d = '0;
      end else if (load) begin
         data_d = d_data;
         ctrl_d = d_ctrl;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         data_q <= '0;
         ctrl_q <= '0;
      end else begin
         data_q <= data_d;
         ctrl_q <= ctrl_d;
      end
   end

   assign q_data = data_q;
   assign q_ctrl = ctrl_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid -- valid/ready pipeline register with a 2-entry skid buffer.
// in_ready comes straight from flops, so there is no combinational path from
// out_ready back to in_ready. Flush empties the stage and zeroes control.
// Optional build macro: PIPE_STAGE_PERF_EN adds stall_cnt / bubble_cnt.
// Ports:
//   clk, rst                      : clock / asynchronous active-low reset
//   in_valid, in_ready            : upstream handshake
//   in_data, in_ctrl              : upstream beat
//   flush                         : synchronous kill of all held beats
//   out_valid, out_ready          : downstream handshake
//   out_data, out_ctrl            : head beat (out_ctrl is 0 when not valid)
//   halted                        : a Halt beat was accepted; input closed
//   stall_cnt, bubble_cnt         : (PIPE_STAGE_PERF_EN) saturating counters
module pipe_stage_skid
   import pipe_pkg::*;
#(
   parameter int DATA_W   = 48,
   parameter int CTRL_W   = 16,
   parameter int HALT_BIT = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic              halted
`ifdef PIPE_STAGE_PERF_EN
   ,
   output logic [PERF_W-1:0] stall_cnt,
   output logic [PERF_W-1:0] bubble_cnt
`endif
);

   state_t state_q, state_d;
   logic   halted_q, halted_d;

   logic   in_fire, out_fire, halt_in;
   logic   m_load, s_load;
   logic   [DATA_W-1:0] m_d_data, m_q_data, s_q_data;
   logic   [CTRL_W-1:0] m_d_ctrl, m_q_ctrl, s_q_ctrl;

   assign in_ready  = (state_q != FULL) & ~halted_q;
   assign out_valid = (state_q != EMPTY);
   assign in_fire   = in_valid & in_ready;
   assign out_fire  = out_valid & out_ready;

   generate
      if (HALT_BIT >= 0) begin : g_halt
         assign halt_in = in_ctrl[HALT_BIT];
      end else begin : g_no_halt
         assign halt_in = 1'b0;
      end
   endgenerate

   // Next state and entry load enables. M refills from S when the stage is
   // FULL (input is blocked then), otherwise from the upstream beat.
   always_comb begin
      state_d  = state_q;
      halted_d = halted_q;
      m_load   = 1'b0;
      s_load   = 1'b0;
      m_d_data = in_data;
      m_d_ctrl = in_ctrl;

      if (flush) begin
         state_d  = EMPTY;
         halted_d = 1'b0;
      end else begin
         if (in_fire && halt_in) begin
            halted_d = 1'b1;
         end
         unique case (state_q)
            EMPTY: begin
               if (in_fire) begin
                  m_load  = 1'b1;
                  state_d = ONE;
               end
            end
            ONE: begin
               if (in_fire && out_fire) begin
                  m_load = 1'b1;
               end else if (in_fire) begin
                  s_load  = 1'b1;
                  state_d = FULL;
               end else if (out_fire) begin
                  state_d = EMPTY;
               end
            end
            FULL: begin
               m_d_data = s_q_data;
               m_d_ctrl = s_q_ctrl;
               if (out_fire) begin
                  m_load  = 1'b1;
                  state_d = ONE;
               end
            end
            default: state_d = EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= EMPTY;
         halted_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         halted_q <= halted_d;
      end
   end

   pipe_entry #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_m (
      .clk      (clk),
      .rst      (rst),
      .load     (m_load),
      .clr_ctrl (flush),
      .d_data   (m_d_data),
      .d_ctrl   (m_d_ctrl),
      .q_data   (m_q_data),
      .q_ctrl   (m_q_ctrl)
   );

   pipe_entry #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_s (
      .clk      (clk),
      .rst      (rst),
      .load     (s_load),
      .clr_ctrl (flush),
      .d_data   (in_data),
      .d_ctrl   (in_ctrl),
      .q_data   (s_q_data),
      .q_ctrl   (s_q_ctrl)
   );

   assign out_data = m_q_data;
   // M keeps stale control after draining to EMPTY; mask it so an empty
   // stage always presents a NOP.
   assign out_ctrl = out_valid ? m_q_ctrl : '0;
   assign halted   = halted_q;

`ifdef PIPE_STAGE_PERF_EN
   logic [PERF_W-1:0] stall_q, stall_d, bubble_q, bubble_d;

   always_comb begin
      stall_d  = sat_inc(stall_q, out_valid & ~out_ready);
      bubble_d = sat_inc(bubble_q, ~out_valid);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_q  <= '0;
         bubble_q <= '0;
      end else begin
         stall_q  <= stall_d;
         bubble_q <= bubble_d;
      end
   end

   assign stall_cnt  = stall_q;
   assign bubble_cnt = bubble_q;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Testbench for pipe_stage_skid. The reference model is a bounded queue
// (capacity 2) plus a halted flag; expected outputs come from the queue head.
// Build with PIPE_STAGE_PERF_EN defined to also exercise the counters.
module tb_pipe_stage_skid;
   localparam int DW = 48;
   localparam int CW = 16;

   typedef struct packed {
      logic [DW-1:0] d;
      logic [CW-1:0] c;
   } beat_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid, in_ready, flush, out_valid, out_ready, halted;
   logic [DW-1:0] in_data, out_data;
   logic [CW-1:0] in_ctrl, out_ctrl;
`ifdef PIPE_STAGE_PERF_EN
   logic [15:0]   stall_cnt, bubble_cnt;
`endif

   int n_cmp  = 0;
   int n_fail = 0;

   // reference model
   beat_t         mq[$];
   logic          m_halted = 1'b0;
   logic [15:0]   m_stall  = '0;
   logic [15:0]   m_bubble = '0;

   always #5 clk = ~clk;

   pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .HALT_BIT(0)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_ctrl   (in_ctrl),
      .flush     (flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_ctrl  (out_ctrl),
      .halted    (halted)
`ifdef PIPE_STAGE_PERF_EN
      ,
      .stall_cnt (stall_cnt),
      .bubble_cnt(bubble_cnt)
`endif
   );

   function automatic logic exp_valid();
      return mq.size() > 0;
   endfunction
   function automatic logic exp_ready();
      return (mq.size() < 2) && !m_halted;
   endfunction
   function automatic logic [CW-1:0] exp_ctrl();
      return (mq.size() > 0) ? mq[0].c : '0;
   endfunction
   function automatic logic [DW-1:0] exp_data();
      return (mq.size() > 0) ? mq[0].d : '0;
   endfunction

   function automatic logic [15:0] sat1(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   task automatic model_clear();
      mq.delete();
      m_halted = 1'b0;
      m_stall  = '0;
      m_bubble = '0;
   endtask

   // Drive one cycle from a negedge; returns at the following negedge with
   // the model advanced to match the clock edge in between.
   task automatic drive(input logic iv, input logic [DW-1:0] id,
                        input logic [CW-1:0] ic, input logic orr,
                        input logic fl);
      logic ifire, ofire;
      beat_t b;
      in_valid  = iv;
      in_data   = id;
      in_ctrl   = ic;
      out_ready = orr;
      flush     = fl;
      ifire = rst && iv && (mq.size() < 2) && !m_halted;
      ofire = rst && (mq.size() > 0) && orr;
      @(posedge clk);
      if (!rst) begin
         model_clear();
      end else begin
         if (mq.size() > 0 && !orr) m_stall = sat1(m_stall);
         if (mq.size() == 0)        m_bubble = sat1(m_bubble);
         if (fl) begin
            mq.delete();
            m_halted = 1'b0;
         end else begin
            if (ofire) void'(mq.pop_front());
            if (ifire) begin
               b.d = id;
               b.c = ic;
               mq.push_back(b);
               if (ic[0]) m_halted = 1'b1;
            end
         end
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 48'd99, 16'h0004, 1'b1, 1'b0);
         n_cmp++;
         if (out_valid !== 1'b0 || out_ctrl !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_out cyc%0d: out_valid=%b out_ctrl=%h, want 0/0000", i, out_valid, out_ctrl);
         end
         n_cmp++;
         if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready cyc%0d: got %b want 1", i, in_ready);
         end
      end
      rst = 1'b1;
   endtask

   task automatic test_stream();
      for (int i = 1; i <= 3; i++) begin
         drive(1'b1, DW'(i), 16'h0004, 1'b1, 1'b0);
         n_cmp++;
         if (out_valid !== 1'b1 || out_data !== DW'(i) || out_ctrl !== 16'h0004 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL stream beat%0d: v=%b d=%0d c=%h rdy=%b, want 1/%0d/0004/1", i, out_valid, out_data, out_ctrl, in_ready, i);
         end
      end
      drive(1'b0, '0, '0, 1'b1, 1'b0);
      n_cmp++;
      if (out_valid !== 1'b0 || out_ctrl !== 16'h0) begin
         n_fail++;
         $display("FAIL stream_drain: v=%b c=%h, want 0/0000", out_valid, out_ctrl);
      end
      $display("test_stream done");
   endtask

   task automatic test_backpressure();
      drive(1'b1, 48'd5, 16'h0004, 1'b0, 1'b0);
      drive(1'b1, 48'd6, 16'h0004, 1'b0, 1'b0);
      n_cmp++;
      if (in_ready !== 1'b0 || out_data !== 48'd5) begin
         n_fail++;
         $display("FAIL bp_full: in_ready=%b d=%0d, want 0/5", in_ready, out_data);
      end
      drive(1'b1, 48'd7, 16'h0004, 1'b0, 1'b0);   // refused: stage FULL
      n_cmp++;
      if (in_ready !== 1'b0 || out_data !== 48'd5 || out_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL bp_hold: in_ready=%b v=%b d=%0d, want 0/1/5", in_ready, out_valid, out_data);
      end
      drive(1'b1, 48'd7, 16'h0004, 1'b1, 1'b0);   // 5 leaves, 7 still refused
      n_cmp++;
      if (out_data !== 48'd6 || in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL bp_second: d=%0d rdy=%b, want 6/1", out_data, in_ready);
      end
      drive(1'b1, 48'd7, 16'h0004, 1'b1, 1'b0);
      n_cmp++;
      if (out_data !== 48'd7 || out_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL bp_third: v=%b d=%0d, want 1/7", out_valid, out_data);
      end
      drive(1'b0, '0, '0, 1'b1, 1'b0);
      n_cmp++;
      if (out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL bp_drain: v=%b want 0 (duplicate beat)", out_valid);
      end
      $display("test_backpressure done");
   endtask

   task automatic test_flush();
      drive(1'b1, 48'd8, 16'h0004, 1'b0, 1'b0);
      drive(1'b1, 48'd9, 16'h0004, 1'b0, 1'b0);
      drive(1'b1, 48'd10, 16'h0004, 1'b0, 1'b1);
      n_cmp++;
      if (out_valid !== 1'b0 || out_ctrl !== 16'h0 || in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL flush_full: v=%b c=%h rdy=%b, want 0/0000/1", out_valid, out_ctrl, in_ready);
      end
      for (int i = 0; i < 2; i++) begin
         drive(1'b0, '0, '0, 1'b1, 1'b0);
         n_cmp++;
         if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_dropped cyc%0d: v=%b d=%0d, want v=0", i, out_valid, out_data);
         end
      end
      $display("test_flush done");
   endtask

   task automatic test_halt();
      drive(1'b1, 48'd11, 16'h0001, 1'b0, 1'b0);
      n_cmp++;
      if (halted !== 1'b1 || in_ready !== 1'b0 || out_data !== 48'd11) begin
         n_fail++;
         $display("FAIL halt_set: halted=%b rdy=%b d=%0d, want 1/0/11", halted, in_ready, out_data);
      end
      drive(1'b1, 48'd12, 16'h0004, 1'b1, 1'b0);   // 11 drains, 12 refused
      n_cmp++;
      if (out_valid !== 1'b0 || halted !== 1'b1 || in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL halt_drain: v=%b halted=%b rdy=%b, want 0/1/0", out_valid, halted, in_ready);
      end
      drive(1'b1, 48'd12, 16'h0004, 1'b1, 1'b0);
      n_cmp++;
      if (out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL halt_closed: v=%b d=%0d, want 0", out_valid, out_data);
      end
      drive(1'b0, '0, '0, 1'b1, 1'b1);
      n_cmp++;
      if (halted !== 1'b0 || in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL halt_flush: halted=%b rdy=%b, want 0/1", halted, in_ready);
      end
      drive(1'b1, 48'd12, 16'h0004, 1'b1, 1'b0);
      n_cmp++;
      if (out_valid !== 1'b1 || out_data !== 48'd12) begin
         n_fail++;
         $display("FAIL halt_reopen: v=%b d=%0d, want 1/12", out_valid, out_data);
      end
      drive(1'b0, '0, '0, 1'b1, 1'b0);
      $display("test_halt done");
   endtask

   task automatic test_async_reset();
      drive(1'b1, 48'd20, 16'h0004, 1'b0, 1'b0);
      drive(1'b1, 48'd21, 16'h0006, 1'b0, 1'b0);
      n_cmp++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL areset_pre: v=%b rdy=%b, want 1/0", out_valid, in_ready);
      end
      #2 rst = 1'b0;   // between edges
      #1;
      model_clear();
      n_cmp++;
      if (out_valid !== 1'b0 || out_ctrl !== 16'h0 || in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL areset_now: v=%b c=%h rdy=%b, want 0/0000/1", out_valid, out_ctrl, in_ready);
      end
      @(negedge clk);
      rst = 1'b1;
      drive(1'b0, '0, '0, 1'b1, 1'b0);
      n_cmp++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL areset_empty: v=%b rdy=%b, want 0/1", out_valid, in_ready);
      end
      drive(1'b1, 48'd22, 16'h0004, 1'b1, 1'b0);
      n_cmp++;
      if (out_valid !== 1'b1 || out_data !== 48'd22) begin
         n_fail++;
         $display("FAIL areset_after: v=%b d=%0d, want 1/22", out_valid, out_data);
      end
      drive(1'b0, '0, '0, 1'b1, 1'b0);
      $display("test_async_reset done");
   endtask

   task automatic test_random();
      logic [CW-1:0] c;
      for (int i = 0; i < 400; i++) begin
         c = CW'($urandom);
         c[0] = ($urandom_range(0, 15) == 0);
         drive($urandom_range(0, 3) != 0, {16'($urandom), 32'($urandom)}, c,
               $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0);
         n_cmp++;
         if (out_valid !== exp_valid() || in_ready !== exp_ready() || halted !== m_halted ||
             out_ctrl !== exp_ctrl() || (exp_valid() && out_data !== exp_data())) begin
            n_fail++;
            $display("FAIL random cyc%0d: v=%b rdy=%b h=%b c=%h d=%h, want %b/%b/%b/%h/%h",
                     i, out_valid, in_ready, halted, out_ctrl, out_data,
                     exp_valid(), exp_ready(), m_halted, exp_ctrl(), exp_data());
         end
      end
      drive(1'b0, '0, '0, 1'b1, 1'b1);
      $display("test_random done");
   endtask

`ifdef PIPE_STAGE_PERF_EN
   task automatic test_perf();
      rst = 1'b0;
      @(negedge clk);
      model_clear();
      rst = 1'b1;
      for (int i = 0; i < 4; i++) drive(1'b0, '0, '0, 1'b1, 1'b0);
      n_cmp++;
      if (bubble_cnt !== 16'd4 || bubble_cnt !== m_bubble || stall_cnt !== 16'd0) begin
         n_fail++;
         $display("FAIL perf_bubble: bubble=%0d stall=%0d, want 4/0", bubble_cnt, stall_cnt);
      end
      drive(1'b1, 48'd30, 16'h0004, 1'b0, 1'b0);
      for (int i = 0; i < 70000; i++) drive(1'b0, '0, '0, 1'b0, 1'b0);
      n_cmp++;
      if (stall_cnt !== 16'hFFFF || stall_cnt !== m_stall || bubble_cnt !== m_bubble) begin
         n_fail++;
         $display("FAIL perf_stall: stall=%h bubble=%0d, want ffff/%0d", stall_cnt, bubble_cnt, m_bubble);
      end
      drive(1'b0, '0, '0, 1'b0, 1'b1);   // flush leaves counters alone
      n_cmp++;
      if (stall_cnt !== 16'hFFFF || bubble_cnt !== m_bubble) begin
         n_fail++;
         $display("FAIL perf_flush: stall=%h bubble=%0d, want ffff/%0d", stall_cnt, bubble_cnt, m_bubble);
      end
      $display("test_perf done");
   endtask
`endif

   initial begin
      rst = 1'b0; in_valid = 1'b0; in_data = '0; in_ctrl = '0;
      out_ready = 1'b0; flush = 1'b0;
      @(negedge clk);
      test_reset();
      test_stream();
      test_backpressure();
      test_flush();
      test_halt();
      test_async_reset();
      test_random();
`ifdef PIPE_STAGE_PERF_EN
      test_perf();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised successor to the fixed-field inter-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) of the 16-bit core.
- Carries a generic data bundle and a control bundle between stages.
- Uses a valid/ready handshake with a 2-entry skid buffer, so stalls are absorbed without a combinational ready path.
- Flush inserts bubbles; control is zeroed, so downstream sees a NOP.

Parameters:
DATA_W, 48, payload width (PC+2, ALU result, store data etc.); not cleared on flush
CTRL_W, 16, control width (RegWrite, MemWrite, Halt, err flags etc.); zeroed on flush and when the stage is empty
HALT_BIT, 0, index in ctrl of the Halt flag; -1 disables halt-hold

Ports:
clk  in  1  clock, all flops rising edge
rst  in  1  reset; asynchronous, active-low (asserted at 0)
in_valid  in  1  upstream beat valid
in_ready  out  1  stage can accept a beat; driven directly from state flops
in_data  in  DATA_W  upstream payload
in_ctrl  in  CTRL_W  upstream control
flush  in  1  synchronous kill of all held beats
out_valid  out  1  head entry valid
out_ready  in  1  downstream accepts head
out_data  out  DATA_W  head payload
out_ctrl  out  CTRL_W  head control; all zeros when out_valid=0
halted  out  1  a Halt beat has been accepted and the stage is now closed

Behaviour:
- Storage: main entry M (head) and skid entry S. States: EMPTY, ONE (M valid), FULL (M and S valid).
- Handshake events:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
  - in_ready = (state != FULL) & ~halted.
  - out_valid = (state != EMPTY).
  - in_valid may be withdrawn without a fire; the stage never drops an accepted beat except on flush.
- Transitions (flush=0):
  - EMPTY: on in_fire, M<=in, go to ONE.
  - ONE: in_fire & out_fire: M<=in, stay ONE. in_fire only: S<=in, go to FULL. out_fire only: go to EMPTY.
  - FULL: on out_fire, M<=S, go to ONE. in_ready=0, so no input is taken.
- Latency and ordering:
  - Latency is 1 cycle: a beat accepted at edge n is at the output after edge n.
  - Full throughput of 1 beat/cycle when out_ready stays high.
  - Order is strictly FIFO.
- Flush:
  - Highest priority: next state is EMPTY, M.ctrl and S.ctrl are cleared to 0, halted is cleared.
  - A beat presented in the flush cycle is dropped, even if in_fire.
  - A simultaneous out_fire still counts as consumed downstream.
  - Data fields keep their old values.
- Halt-hold (HALT_BIT>=0):
  - Accepting a beat with in_ctrl[HALT_BIT]=1 sets halted at the next edge.
  - halted forces in_ready=0 until flush or reset. Beats already held still drain normally.
- Reset (rst=0, asynchronous):
  - state=EMPTY, halted=0, all ctrl flops 0, data flops 0.
  - Hence out_valid=0 and out_ctrl=0 immediately.
  - in_ready reads 1, but no beat is captured while rst=0.
  - Reset mid-transfer discards both entries.
- Widths: no arithmetic apart from the optional counters. All widths are exact, with no truncation.

Optional Feature:
- Macro: PIPE_STAGE_PERF_EN.
- When defined, adds outputs stall_cnt[15:0] and bubble_cnt[15:0]:
  - stall_cnt increments each cycle where out_valid & ~out_ready.
  - bubble_cnt increments each cycle where ~out_valid.
  - Both saturate at 16'hFFFF, reset to 0 on rst, and are unaffected by flush.
- When undefined, neither the ports nor the counters exist.

Decomposition:
- Shared package pipe_pkg: state encoding (EMPTY=2'b00, ONE=2'b01, FULL=2'b11), HALT_NONE=-1, counter width PERF_W=16.
- One sub-module: pipe_entry, a DATA_W+CTRL_W register with load enable and ctrl-only synchronous clear. It is instantiated twice (M and S).
- The FSM and halted flag live in the top module.

Test Plan:
- Reset then stream: rst low 3 cycles, then beats ctrl=16'h0004 with data 1,2,3, out_ready=1 -> out_valid=0 and out_ctrl=0 during reset; outputs 1,2,3 on consecutive cycles, each 1 cycle after input; in_ready stays 1.
- Backpressure: send data 5,6,7 with out_ready=0 -> state FULL after 6, in_ready=0 while 7 is held upstream; raise out_ready -> outputs 5,6,7 in order, none lost or duplicated.
- Flush while FULL: hold 8,9, assert flush with in_valid for 10 -> next cycle out_valid=0, out_ctrl=0, in_ready=1; 10 never appears at the output.
- Halt: accept ctrl[0]=1 with data 11, then offer 12 -> halted=1 and in_ready=0; 11 drains; 12 is not accepted until flush, after which halted=0.
- Async reset mid-FULL: drop rst between edges -> out_valid and out_ctrl go to 0 without waiting for a clock; after release the stage is EMPTY.
- PIPE_STAGE_PERF_EN: hold out_valid=1, out_ready=0 for 70000 cycles -> stall_cnt saturates at 16'hFFFF; empty for 4 cycles -> bubble_cnt=4.
